// File: rtl/cp0.sv
// CP0: system control coprocessor holding SR, Cause, EPC and PRId.
// Raises Req for interrupts/exceptions and records the exception context.
module cp0 #(
    parameter logic [31:0] PRID = 32'h0000_B007
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  CP0Add,
    input  logic [31:0] CP0In,
    output logic [31:0] CP0Out,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] EPCOut,
    output logic        Req
);

    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic [31:0] sr_val;
    logic [31:0] cause_val;

    // Request generation from live interrupt lines and the pre-edge EXL.
    always_comb begin
        int_req = (|(HWInt & im)) & ie & ~exl;
        exc_req = (ExcCodeIn != 5'd0) & ~exl;
        Req     = (int_req | exc_req) & ~reset;
    end

    // Register images as seen by mfc0; unimplemented bits read zero.
    always_comb begin
        sr_val    = {16'h0, im, 8'h0, exl, ie};
        cause_val = {bd, 15'h0, ip, 3'h0, exc_code, 2'h0};
        case (CP0Add)
            5'd12:   CP0Out = sr_val;
            5'd13:   CP0Out = cause_val;
            5'd14:   CP0Out = epc;
            5'd15:   CP0Out = PRID;
            default: CP0Out = 32'h0;
        endcase
    end

    assign EPCOut = epc;

    // State update: reset, then exception entry, then eret/mtc0.
    always_ff @(posedge clk) begin
        if (reset) begin
            im       <= 6'h0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= 6'h0;
            exc_code <= 5'h0;
            epc      <= 32'h0;
        end else begin
            ip <= HWInt;
            if (Req) begin
                exl      <= 1'b1;
                exc_code <= int_req ? 5'd0 : ExcCodeIn;
                bd       <= BDIn;
                epc      <= BDIn ? VPC - 32'd4 : VPC;
            end else begin
                if (en && CP0Add == 5'd12) begin
                    im  <= CP0In[15:10];
                    exl <= CP0In[1] & ~EXLClr;
                    ie  <= CP0In[0];
                end else if (EXLClr) begin
                    exl <= 1'b0;
                end
                if (en && CP0Add == 5'd14) begin
                    epc <= CP0In;
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0.sv
// Self-checking bench for cp0: directed scenarios plus randomized
// stimulus compared against a register-level reference model.
module tb_cp0;

    localparam logic [31:0] PRID = 32'h0000_B007;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [4:0]  CP0Add;
    logic [31:0] CP0In;
    logic [31:0] CP0Out;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] EPCOut;
    logic        Req;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_sr;
    logic [31:0] m_cause;
    logic [31:0] m_epc;

    cp0 #(.PRID(PRID)) dut (
        .clk(clk), .reset(reset), .en(en), .CP0Add(CP0Add),
        .CP0In(CP0In), .CP0Out(CP0Out), .VPC(VPC), .BDIn(BDIn),
        .ExcCodeIn(ExcCodeIn), .HWInt(HWInt), .EXLClr(EXLClr),
        .EPCOut(EPCOut), .Req(Req)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a);
        CP0Add = a;
        #1;
    endtask

    task automatic idle();
        reset = 0; en = 0; CP0Add = 0; CP0In = 0; VPC = 0;
        BDIn = 0; ExcCodeIn = 0; HWInt = 0; EXLClr = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        reset = 0;
        m_sr = 0; m_cause = 0; m_epc = 0;
    endtask

    function automatic logic m_int();
        return !reset && !m_sr[1] && m_sr[0] &&
               ((HWInt & m_sr[15:10]) != 6'd0);
    endfunction

    function automatic logic m_req();
        return !reset && !m_sr[1] && (m_int() || ExcCodeIn != 5'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model across one clock edge using the current inputs.
    task automatic model_edge();
        logic r, i;
        r = m_req();
        i = m_int();
        if (reset) begin
            m_sr = 0; m_cause = 0; m_epc = 0;
        end else if (r) begin
            m_sr    = m_sr | 32'h2;
            m_cause = ({31'h0, BDIn} << 31) | ({26'h0, HWInt} << 10)
                    | ((i ? 32'h0 : {27'h0, ExcCodeIn}) << 2);
            m_epc   = BDIn ? VPC - 32'd4 : VPC;
        end else begin
            m_cause = (m_cause & ~32'h0000_FC00) | ({26'h0, HWInt} << 10);
            if (en && CP0Add == 5'd12) m_sr = CP0In & 32'h0000_FC03;
            if (en && CP0Add == 5'd14) m_epc = CP0In;
            if (EXLClr) m_sr = m_sr & ~32'h2;
        end
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        VPC = 32'h1234; ExcCodeIn = 5'd3;
        #1;
        checks++;
        if (Req !== 1'b0) begin
            failures++; $display("FAIL reset_req got %b want 0", Req);
        end
        tick();
        idle();
        for (int a = 12; a <= 15; a++) begin
            rd(a[4:0]);
            checks++;
            if (CP0Out !== (a == 15 ? PRID : 32'h0)) begin
                failures++;
                $display("FAIL reset_reg%0d got %h want %h", a, CP0Out,
                         (a == 15 ? PRID : 32'h0));
            end
        end
        checks++;
        if (EPCOut !== 32'h0) begin
            failures++; $display("FAIL reset_epcout got %h want 0", EPCOut);
        end
    endtask

    task automatic test_interrupt_entry();
        do_reset();
        en = 1; CP0Add = 5'd12; CP0In = 32'h0000_0401;
        tick();
        en = 0; HWInt = 6'b000001; VPC = 32'h0000_3010; BDIn = 0;
        #1;
        checks++;
        if (Req !== 1'b1) begin
            failures++; $display("FAIL int_req got %b want 1", Req);
        end
        tick();
        HWInt = 0;
        rd(5'd12);
        checks++;
        if (CP0Out !== 32'h0000_0403) begin
            failures++; $display("FAIL int_sr got %h want 00000403", CP0Out);
        end
        rd(5'd13);
        checks++;
        if (CP0Out[6:2] !== 5'd0) begin
            failures++; $display("FAIL int_exccode got %h want 0", CP0Out[6:2]);
        end
        checks++;
        if (EPCOut !== 32'h0000_3010) begin
            failures++; $display("FAIL int_epc got %h want 00003010", EPCOut);
        end
    endtask

    task automatic test_delay_slot();
        do_reset();
        ExcCodeIn = 5'd12; BDIn = 1; VPC = 32'h0000_3008;
        #1;
        checks++;
        if (Req !== 1'b1) begin
            failures++; $display("FAIL bd_req got %b want 1", Req);
        end
        tick();
        ExcCodeIn = 0; BDIn = 0;
        checks++;
        if (EPCOut !== 32'h0000_3004) begin
            failures++; $display("FAIL bd_epc got %h want 00003004", EPCOut);
        end
        rd(5'd13);
        checks++;
        if (CP0Out !== 32'h8000_0030) begin
            failures++; $display("FAIL bd_cause got %h want 80000030", CP0Out);
        end
    endtask

    // Runs right after the delay-slot test, so EXL=1 and EPC=3004.
    task automatic test_masking();
        en = 1; CP0Add = 5'd12; CP0In = 32'h0000_0403;
        tick();
        en = 0; ExcCodeIn = 5'd4; HWInt = 6'b000001; VPC = 32'h0000_5000;
        #1;
        checks++;
        if (Req !== 1'b0) begin
            failures++; $display("FAIL mask_req got %b want 0", Req);
        end
        tick();
        checks++;
        if (EPCOut !== 32'h0000_3004) begin
            failures++; $display("FAIL mask_epc got %h want 00003004", EPCOut);
        end
        rd(5'd13);
        checks++;
        if (CP0Out[15:10] !== 6'b000001) begin
            failures++; $display("FAIL mask_ip got %b want 000001", CP0Out[15:10]);
        end
        ExcCodeIn = 0; EXLClr = 1;
        #1;
        checks++;
        if (Req !== 1'b0) begin
            failures++; $display("FAIL clr_req_pre got %b want 0", Req);
        end
        tick();
        EXLClr = 0;
        rd(5'd12);
        checks++;
        if (CP0Out !== 32'h0000_0401) begin
            failures++; $display("FAIL clr_sr got %h want 00000401", CP0Out);
        end
        checks++;
        if (Req !== 1'b1) begin
            failures++; $display("FAIL clr_req_post got %b want 1", Req);
        end
        tick();
        HWInt = 0;
        rd(5'd12);
        checks++;
        if (CP0Out[1] !== 1'b1) begin
            failures++; $display("FAIL clr_reenter got %b want 1", CP0Out[1]);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        en = 1; CP0Add = 5'd12; CP0In = 32'h0000_FC01;
        tick();
        HWInt = 6'b100000; ExcCodeIn = 5'd10; en = 1; CP0Add = 5'd14;
        CP0In = 32'hDEAD_BEEF; VPC = 32'h0000_4000; BDIn = 0;
        #1;
        checks++;
        if (Req !== 1'b1) begin
            failures++; $display("FAIL sim_req got %b want 1", Req);
        end
        tick();
        en = 0; ExcCodeIn = 0;
        checks++;
        if (EPCOut !== 32'h0000_4000) begin
            failures++; $display("FAIL sim_epc got %h want 00004000", EPCOut);
        end
        rd(5'd13);
        checks++;
        if (CP0Out !== 32'h0000_8000) begin
            failures++; $display("FAIL sim_cause got %h want 00008000", CP0Out);
        end
        rd(5'd12);
        checks++;
        if (CP0Out !== 32'h0000_FC03) begin
            failures++; $display("FAIL sim_sr got %h want 0000fc03", CP0Out);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        en = 1; CP0Add = 5'd12; CP0In = 32'h0000_FC01;
        tick();
        en = 1; CP0Add = 5'd14; CP0In = 32'h0000_0777;
        HWInt = 6'b111111; ExcCodeIn = 5'd5; VPC = 32'h0000_6000;
        reset = 1;
        #1;
        checks++;
        if (Req !== 1'b0) begin
            failures++; $display("FAIL rmid_req got %b want 0", Req);
        end
        tick();
        idle();
        for (int a = 12; a <= 16; a++) begin
            rd(a[4:0]);
            checks++;
            if (CP0Out !== (a == 15 ? PRID : 32'h0)) begin
                failures++;
                $display("FAIL rmid_reg%0d got %h want %h", a, CP0Out,
                         (a == 15 ? PRID : 32'h0));
            end
        end
    endtask

    task automatic test_random();
        logic [4:0] addrs [5];
        addrs[0] = 5'd12; addrs[1] = 5'd13; addrs[2] = 5'd14;
        addrs[3] = 5'd15; addrs[4] = 5'd0;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            reset     = ($urandom_range(0, 49) == 0);
            en        = ($urandom_range(0, 2) == 0);
            CP0Add    = ($urandom_range(0, 4) == 0) ? 5'($urandom)
                        : addrs[$urandom_range(0, 3)];
            CP0In     = $urandom;
            VPC       = $urandom;
            BDIn      = 1'($urandom);
            ExcCodeIn = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
            HWInt     = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            EXLClr    = ($urandom_range(0, 5) == 0);
            #1;
            checks++;
            if (Req !== m_req()) begin
                failures++;
                $display("FAIL rnd_req n=%0d got %b want %b", n, Req, m_req());
            end
            checks++;
            if (CP0Out !== m_read(CP0Add)) begin
                failures++;
                $display("FAIL rnd_read n=%0d addr=%0d got %h want %h",
                         n, CP0Add, CP0Out, m_read(CP0Add));
            end
            checks++;
            if (EPCOut !== m_epc) begin
                failures++;
                $display("FAIL rnd_epc n=%0d got %h want %h", n, EPCOut, m_epc);
            end
            model_edge();
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        m_sr = 0; m_cause = 0; m_epc = 0;
        #1;
        test_reset();
        test_interrupt_entry();
        test_delay_slot();
        test_masking();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cp0.md
CP0 -- requirements
Module: cp0

Interface
REQ-001 The block SHALL have parameter PRID, default 32'h0000_B007, which is the read-only value of register 15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port en, input, 1 bit: mtc0 write enable.
REQ-005 The block SHALL have port CP0Add, input, 5 bits: register number for both read and write.
REQ-006 The block SHALL have port CP0In, input, 32 bits: mtc0 write data.
REQ-007 The block SHALL have port CP0Out, output, 32 bits: mfc0 read data, combinational.
REQ-008 The block SHALL have port VPC, input, 32 bits: PC of the victim instruction in the commit stage.
REQ-009 The block SHALL have port BDIn, input, 1 bit: the victim instruction is in a branch delay slot.
REQ-010 The block SHALL have port ExcCodeIn, input, 5 bits: exception code from the pipeline; 0 means no exception.
REQ-011 The block SHALL have port HWInt, input, 6 bits: external interrupt lines, level-sensitive.
REQ-012 The block SHALL have port EXLClr, input, 1 bit: eret committing.
REQ-013 The block SHALL have port EPCOut, output, 32 bits: current EPC register, consumed by next-PC logic on eret.
REQ-014 The block SHALL have port Req, output, 1 bit: take exception/interrupt this cycle (flush pipeline, redirect fetch to handler).

Function
REQ-015 SR (reg 12) SHALL implement IM = bits[15:10], EXL = bit[1], IE = bit[0]; all other bits SHALL read 0.
REQ-016 Cause (reg 13) SHALL implement BD = bit[31], IP = bits[15:10], ExcCode = bits[6:2]; all other bits SHALL read 0.
REQ-017 EPC (reg 14) SHALL be a 32-bit register.
REQ-018 Reg 15 SHALL read PRID; any other address SHALL read 32'h0.
REQ-019 CP0Out SHALL be a combinational read of the register currently addressed by CP0Add.
REQ-020 Cause.IP SHALL be loaded with HWInt on every non-reset clock edge, so it lags HWInt by one cycle.
REQ-021 IntReq SHALL equal (|(HWInt & IM)) & IE & ~EXL, using live HWInt (zero cycles of latency).
REQ-022 ExcReq SHALL equal (ExcCodeIn != 0) & ~EXL.
REQ-023 Req SHALL equal (IntReq | ExcReq) & ~reset.
REQ-024 When Req=1, on the clock edge: EXL <= 1.
REQ-025 When Req=1, on the clock edge: ExcCode <= (IntReq ? 5'd0 : ExcCodeIn), i.e. an interrupt has priority over a simultaneous exception.
REQ-026 When Req=1, on the clock edge: BD <= BDIn.
REQ-027 When Req=1, on the clock edge: EPC <= (BDIn ? VPC - 32'd4 : VPC), with the subtraction modulo 2^32.
REQ-028 When Req=1, SR.IE and SR.IM SHALL be unchanged.
REQ-029 An mtc0 write (en=1, Req=0) SHALL update the addressed register on the clock edge.
REQ-030 mtc0 writes to SR SHALL load only IM/EXL/IE from CP0In.
REQ-031 mtc0 writes to EPC SHALL load the full 32 bits.
REQ-032 mtc0 writes to Cause, PRId or unimplemented addresses SHALL be ignored.
REQ-033 When Req=1 and en=1 in the same cycle, Req SHALL take priority and the write SHALL be dropped.
REQ-034 EXLClr=1 SHALL clear EXL on the clock edge.
REQ-035 EXLClr=1 together with an mtc0 write to SR SHALL result in EXL=0, with IM and IE taken from CP0In.
REQ-036 Because EXL=1 masks Req, EXLClr and Req SHALL never both take effect in one cycle; Req is evaluated on the pre-edge EXL.
REQ-037 While EXL=1, exceptions and interrupts SHALL be ignored (no nesting) and pending interrupt levels SHALL remain visible in IP.
REQ-038 EPCOut SHALL equal the EPC register at all times.
REQ-039 EPCOut SHALL reflect an mtc0 EPC write from the following cycle onward.

Reset
REQ-040 On a clock edge with reset=1, SR, Cause and EPC SHALL all become 32'h0.
REQ-041 Reset SHALL take priority over Req, en, EXLClr and the IP update.
REQ-042 Req SHALL be 0 while reset=1.
REQ-043 After reset, CP0Out SHALL read 0 for regs 12, 13 and 14, and PRID for reg 15.

Verification
REQ-044 The bench SHALL cover interrupt entry: reset -> mtc0 SR=32'h0000_0401 -> HWInt=6'b000001, VPC=32'h0000_3010, BDIn=0 -> required: Req=1 in the same cycle; next cycle SR=32'h0000_0403, Cause[6:2]=0, EPC=32'h0000_3010.
REQ-045 The bench SHALL cover a delay-slot exception: ExcCodeIn=5'd12, BDIn=1, VPC=32'h0000_3008, EXL=0 -> required: Req=1; next cycle EPC=32'h0000_3004, Cause=32'h8000_0030.
REQ-046 The bench SHALL cover masking: with EXL=1, assert ExcCodeIn=5'd4 and an enabled HWInt -> required: Req=0 and EPC unchanged; then EXLClr=1 -> required: EXL=0 next cycle and Req=1 in that following cycle if the interrupt is still asserted.
REQ-047 The bench SHALL cover a simultaneous interrupt, exception and mtc0: IE=1, IM=6'b111111, HWInt=6'b100000, ExcCodeIn=5'd10, en=1, CP0Add=14 -> required: ExcCode=0, EPC=VPC (the write is dropped), IP=6'b100000.
REQ-048 The bench SHALL cover reset mid-operation: reset=1 together with Req conditions active -> required: Req=0; next cycle all registers read 0 and reg 15 reads PRID.
